mf_disp_cmd_arb: RTL and testbench

//  Display-clock-domain consumer of the per-lane 4-bit command nibbles produced by the CDC sync stage.

---
 rtl/mf_disp_cmd_arb_if.sv | 37 +++
 rtl/mf_disp_cmd_arb.sv | 132 +++++++++++++
 tb/tb_mf_disp_cmd_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mf_disp_cmd_arb_if.sv
// Command arbiter bus: per-lane command nibbles in, one arbitrated
// command out over valid/ready, plus the per-lane overflow flags and their clears.
interface mf_disp_cmd_arb_if #(
    parameter int NUM = 1
);
    localparam int LW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [4*NUM-1:0] in_cmd;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    out_lane;
    logic [3:0]       out_code;
    logic [NUM-1:0]   overflow;
    logic [NUM-1:0]   ovf_clr;

    // Producer/consumer side: drives commands, ready and clears
    modport master (
        output in_cmd,
        output out_ready,
        output ovf_clr,
        input  out_valid,
        input  out_lane,
        input  out_code,
        input  overflow
    );

    // Arbiter side
    modport slave (
        input  in_cmd,
        input  out_ready,
        input  ovf_clr,
        output out_valid,
        output out_lane,
        output out_code,
        output overflow
    );
endinterface

// File: rtl/mf_disp_cmd_arb.sv
// Display-domain command arbiter: buffers each lane's command nibbles in a
// small FIFO, round-robin arbitrates across lanes into a single output
// register with valid/ready handshake, and flags lanes that dropped commands.
module mf_disp_cmd_arb #(
    parameter int NUM   = 1,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    mf_disp_cmd_arb_if.slave   bus
);
    localparam int LW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int PW = $clog2(DEPTH);

    // Per-lane FIFO status and head, gathered for the arbiter
    logic [NUM-1:0] w_empty;
    logic [NUM-1:0] w_pop;
    logic [NUM-1:0] w_ovf;
    logic [3:0]     w_head [NUM];

    // Output register and round-robin pointer
    logic           r_valid;
    logic [LW-1:0]  r_lane;
    logic [3:0]     r_code;
    logic [LW-1:0]  r_rr_ptr;

    // Arbitration results
    logic           w_reload;
    logic           w_found;
    logic [LW-1:0]  w_grant;
    logic [3:0]     w_grant_code;

    // The output register may take a new command when it is empty or being consumed
    assign w_reload = ~r_valid | bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_lane
            logic [3:0]  r_mem [DEPTH];
            logic [PW:0] r_wr_ptr;
            logic [PW:0] r_rd_ptr;
            logic        r_ovf;
            logic [3:0]  w_nib;
            logic        w_push;
            logic        w_full;
            logic        w_wr_en;
            logic        w_drop;

            assign w_nib   = bus.in_cmd[4*gi +: 4];
            assign w_push  = (w_nib != 4'd0);
            assign w_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) &&
                             (r_wr_ptr[PW] != r_rd_ptr[PW]);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts
            assign w_wr_en = w_push & (~w_full | w_pop[gi]);
            assign w_drop  = w_push & w_full & ~w_pop[gi];

            assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
            assign w_head[gi]  = r_mem[r_rd_ptr[PW-1:0]];
            assign w_pop[gi]   = w_reload & w_found & (w_grant == LW'(gi));
            assign w_ovf[gi]   = r_ovf;

            // FIFO storage write; contents need no reset since pointers gate them
            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    r_mem[r_wr_ptr[PW-1:0]] <= w_nib;
                end
            end

            // FIFO pointers with natural binary rollover including the wrap bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_wr_en)    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            // Sticky overflow flag; a new drop beats a simultaneous clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (bus.ovf_clr[gi]) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    endgenerate

    // Round-robin search: first non-empty lane after the last granted one
    always_comb begin
        int idx;
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_code = 4'd0;
        idx          = 0;
        for (int k = 1; k <= NUM; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM;
            if (!w_found && !w_empty[idx]) begin
                w_found      = 1'b1;
                w_grant      = LW'(idx);
                w_grant_code = w_head[idx];
            end
        end
    end

    // Output register load; lane/code hold when nothing new is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_lane   <= '0;
            r_code   <= 4'd0;
            r_rr_ptr <= LW'(NUM - 1);
        end else if (w_reload) begin
            r_valid <= w_found;
            if (w_found) begin
                r_lane   <= w_grant;
                r_code   <= w_grant_code;
                r_rr_ptr <= w_grant;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_lane  = r_lane;
    assign bus.out_code  = r_code;
    assign bus.overflow  = w_ovf;

endmodule

// File: tb/tb_mf_disp_cmd_arb.sv
// Randomized bench for mf_disp_cmd_arb (NUM=4, DEPTH=4) checked every cycle
// against a queue-based reference model of the lane FIFOs and the arbiter.
module tb_mf_disp_cmd_arb;
    localparam int NUM   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 2;

    logic clk;
    logic rst;

    mf_disp_cmd_arb_if #(.NUM(NUM)) bus ();

    mf_disp_cmd_arb #(.NUM(NUM), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model state
    int          mq [NUM][$];
    bit          m_valid;
    int          m_lane;
    int          m_code;
    int          m_rr;
    bit [NUM-1:0] m_ovf;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NUM; l++) mq[l].delete();
        m_valid = 1'b0;
        m_lane  = 0;
        m_code  = 0;
        m_rr    = NUM - 1;
        m_ovf   = '0;
    endtask

    // One clock edge of behaviour: arbitration on pre-edge contents, then pushes
    task automatic model_step(input logic [4*NUM-1:0] cmd, input logic rdy,
                              input logic [NUM-1:0] clr);
        int g;
        int c;
        bit drop;
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= NUM; k++) begin
                int idx;
                idx = (m_rr + k) % NUM;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                m_code  = mq[g].pop_front();
                m_lane  = g;
                m_valid = 1'b1;
                m_rr    = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int l = 0; l < NUM; l++) begin
            c    = int'((cmd >> (4 * l)) & 16'hF);
            drop = 1'b0;
            if (c != 0) begin
                if (mq[l].size() < DEPTH) mq[l].push_back(c);
                else drop = 1'b1;
            end
            if (drop)        m_ovf[l] = 1'b1;
            else if (clr[l]) m_ovf[l] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"},    int'(bus.out_valid), int'(m_valid));
        check_val({tag, ".lane"},     int'(bus.out_lane),  m_lane);
        check_val({tag, ".code"},     int'(bus.out_code),  m_code);
        check_val({tag, ".overflow"}, int'(bus.overflow),  int'(m_ovf));
    endtask

    task automatic step(input string tag, input logic [4*NUM-1:0] cmd,
                        input logic rdy, input logic [NUM-1:0] clr);
        @(negedge clk);
        bus.in_cmd    = cmd;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        model_step(cmd, rdy, clr);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        // Asynchronous: outputs clear without waiting for an edge
        check_outputs(tag);
        @(negedge clk);
        bus.in_cmd  = '0;
        bus.ovf_clr = '0;
        rst = 1'b0;
    endtask

    function automatic logic [4*NUM-1:0] rand_cmd(input int pct);
        logic [4*NUM-1:0] v;
        v = '0;
        for (int l = 0; l < NUM; l++) begin
            if ($urandom_range(99) < pct) v[4*l +: 4] = 4'($urandom_range(15, 1));
        end
        return v;
    endfunction

    function automatic logic [NUM-1:0] rand_clr(input int pct);
        logic [NUM-1:0] v;
        for (int l = 0; l < NUM; l++) v[l] = ($urandom_range(99) < pct);
        return v;
    endfunction

    initial begin
        rst           = 1'b1;
        bus.in_cmd    = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single pulse: visible two edges later, then gone
        step("lat", 16'h0005, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++) step("lat_idle", 16'h0000, 1'b1, 4'h0);

        // Simultaneous pushes on all lanes rotate 0..3
        step("all_a", 16'hAAAA, 1'b1, 4'h0);
        for (int i = 0; i < 6; i++) step("all_a_drain", 16'h0000, 1'b1, 4'h0);

        // Lane 1 burst under backpressure, then drain
        for (int i = 1; i <= 6; i++) step("bp_push", 16'(i << 4), 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) step("bp_drain", 16'h0000, 1'b1, 4'h0);

        // Full lane with push and pop in the same cycle
        for (int i = 1; i <= 5; i++) step("fullpp_fill", 16'(i << 8), 1'b0, 4'h0);
        step("fullpp", 16'h0900, 1'b1, 4'h0);
        for (int i = 0; i < 7; i++) step("fullpp_drain", 16'h0000, 1'b1, 4'h0);

        // Overflow on lane 2: clear with concurrent drop, then clear alone
        for (int i = 0; i < 6; i++) step("ovf_fill", 16'h0300, 1'b0, 4'h0);
        step("ovf_clr_drop", 16'h0300, 1'b0, 4'h4);
        step("ovf_clr", 16'h0000, 1'b0, 4'h4);
        for (int i = 0; i < 7; i++) step("ovf_drain", 16'h0000, 1'b1, 4'h0);

        // Random traffic with mixed backpressure
        for (int i = 0; i < 400; i++)
            step("rnd_a", rand_cmd(35), logic'($urandom_range(1)), rand_clr(5));

        // Heavy traffic, stalled, then reset mid-operation
        for (int i = 0; i < 10; i++) step("pre_rst", rand_cmd(80), 1'b0, 4'h0);
        apply_reset("mid_rst");
        for (int i = 0; i < 5; i++) step("post_rst", 16'h0000, 1'b1, 4'h0);

        // Random traffic mostly ready
        for (int i = 0; i < 400; i++)
            step("rnd_b", rand_cmd(25), logic'($urandom_range(9) != 0), rand_clr(3));
        for (int i = 0; i < 24; i++) step("final_drain", 16'h0000, 1'b1, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
